// File: rtl/afifo_wr_arb_pkg.sv
// Shared types and header packing for the afifo write-port arbiter.
// The header format is only emitted when AFIFO_ARB_HDR_EN is defined.
package afifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_st_e;

    // Header word layout: len occupies the low LW bits, the requester id sits directly above it.
    localparam int HDR_LEN_LSB = 0;

    function automatic int hdr_id_lsb(input int unsigned lw);
        return HDR_LEN_LSB + int'(lw);
    endfunction

    function automatic logic [63:0] hdr_pack(input logic [31:0] id, input logic [31:0] len,
                                             input int unsigned lw);
        logic [63:0] len_m;
        len_m = {32'd0, len} & ((64'd1 << lw) - 64'd1);
        return ({32'd0, id} << hdr_id_lsb(lw)) | (len_m << HDR_LEN_LSB);
    endfunction

endpackage

// File: rtl/afifo_wr_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod N) wins.
module rr_arb #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx,
    output logic [N-1:0]   onehot
);

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 1; k <= N; k++) begin
            int cand;
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDW'(cand);
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter for the afifo write port (write clock domain).
// Define AFIFO_ARB_HDR_EN to prefix every burst with one {id, len} header word.
module afifo_wr_arb
    import afifo_arb_pkg::*;
#(
    parameter  int NR  = 4,
    parameter  int DW  = 128,
    parameter  int LW  = 8,
    localparam int IDW = $clog2(NR)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NR-1:0]    req,
    input  logic [NR*LW-1:0] len,
    input  logic [NR-1:0]    vld,
    input  logic [NR*DW-1:0] din,
    output logic [NR-1:0]    gnt,
    output logic [NR-1:0]    rdy,
    output logic             we,
    output logic [DW-1:0]    dout,
    input  logic             wfull,
    output logic             busy,
    output logic [IDW-1:0]   cur_id
);

    if (NR < 2 || NR > 16) begin : g_nr_chk
        $error("afifo_wr_arb: NR must be in 2..16");
    end

    arb_st_e        state_reg;
    logic [LW-1:0]  cnt_reg;
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] cur_id_reg;
    logic [NR-1:0]  gnt_reg;
    logic           busy_reg;

    logic           arb_any;
    logic [IDW-1:0] arb_idx;
    logic [NR-1:0]  arb_onehot;
    logic [LW-1:0]  win_len;
    logic           vld_cur;
    logic           beat_acc;

    rr_arb #(
        .N   (NR),
        .IDW (IDW)
    ) u_rr_arb (
        .req    (req),
        .ptr    (ptr_reg),
        .any    (arb_any),
        .idx    (arb_idx),
        .onehot (arb_onehot)
    );

    assign win_len  = len[arb_idx*LW +: LW];
    assign vld_cur  = vld[cur_id_reg];
    assign beat_acc = (state_reg == DATA) && vld_cur && !wfull;

`ifdef AFIFO_ARB_HDR_EN
    logic [LW-1:0] len_q_reg;
    logic [DW-1:0] hdr_word;

    if (DW < LW + IDW) begin : g_hdr_width_chk
        $error("afifo_wr_arb: DW too narrow for the {id, len} header word");
    end

    assign hdr_word = DW'(hdr_pack(32'(cur_id_reg), 32'(len_q_reg), LW));
`endif

    // Only the granted requester ever sees rdy, and never while the FIFO is full.
    for (genvar gi = 0; gi < NR; gi++) begin : g_rdy
        assign rdy[gi] = (state_reg == DATA) && (cur_id_reg == IDW'(gi)) && !wfull;
    end

    always_comb begin
        we   = 1'b0;
        dout = '0;
        case (state_reg)
            DATA: begin
                we   = vld_cur && !wfull;
                dout = din[cur_id_reg*DW +: DW];
            end
`ifdef AFIFO_ARB_HDR_EN
            HDR: begin
                we   = !wfull;
                dout = hdr_word;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ptr_reg    <= IDW'(NR - 1);
            gnt_reg    <= '0;
            cur_id_reg <= '0;
            busy_reg   <= 1'b0;
`ifdef AFIFO_ARB_HDR_EN
            len_q_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        gnt_reg    <= arb_onehot;
                        cur_id_reg <= arb_idx;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= win_len;
                        ptr_reg    <= arb_idx;
`ifdef AFIFO_ARB_HDR_EN
                        len_q_reg  <= win_len;
                        state_reg  <= HDR;
`else
                        state_reg  <= DATA;
`endif
                    end
                end
`ifdef AFIFO_ARB_HDR_EN
                HDR: begin
                    if (!wfull) begin
                        state_reg <= DATA;
                    end
                end
`endif
                DATA: begin
                    // cnt holds the beats still owed after this one; zero means last beat.
                    if (beat_acc) begin
                        if (cnt_reg == '0) begin
                            state_reg  <= IDLE;
                            gnt_reg    <= '0;
                            busy_reg   <= 1'b0;
                            cur_id_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt    = gnt_reg;
    assign busy   = busy_reg;
    assign cur_id = cur_id_reg;

endmodule
